// File: rtl/nibble_add_seq.sv
// Nibble-serial sequencer around an external registered 4-bit adder: slices a
// W-bit add/sub into nibbles LSB first and reassembles sum, carry and overflow.
module nibble_add_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4*NIBBLES,
  localparam int KW      = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic          r_cin, r_cout, r_ovf;
  logic [3:0]    w_a_nib, w_b_nib;
  logic          w_last;

  assign w_last = (r_k == KW'(NIBBLES-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DRAIN;
      S_DRAIN:                w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a    <= in_a;
          r_b    <= in_sub ? ~in_b : in_b;
          r_cin  <= in_sub | in_cin;
          r_k    <= '0;
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
        end
        S_RUN: begin
          r_k <= r_k + 1'b1;
          // the adder output now belongs to the nibble issued last cycle
          for (int n = 1; n < NIBBLES; n++)
            if (r_k == KW'(n)) r_sum[4*(n-1) +: 4] <= add_sum;
        end
        S_DRAIN: begin
          r_k              <= '0;
          r_sum[W-1 -: 4]  <= add_sum;
          r_cout           <= add_cout;
          r_ovf            <= (r_a[W-1] == r_b[W-1]) && (add_sum[3] != r_a[W-1]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIBBLES; n++)
      if (r_k == KW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = w_a_nib;
      add_b   = w_b_nib;
      add_cin = (r_k == '0) ? r_cin : add_cout;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule
